// File: rtl/seq_pkg.sv
// Shared types for the step sequencer.
//   note_t  : 3-bit note code consumed by the note-to-interval decoder
//   state_t : sequencer control state
//   step_t  : one pattern entry {active, note}
package seq_pkg;

  typedef enum logic [2:0] {
    C4 = 3'b000,
    D4 = 3'b001,
    B4 = 3'b010,
    E4 = 3'b011,
    F4 = 3'b100,
    A4 = 3'b101,
    G4 = 3'b110,
    C5 = 3'b111
  } note_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  typedef struct packed {
    logic  active;
    note_t note;
  } step_t;

  localparam step_t STEP_CLEARED = '{active: 1'b0, note: C4};

endpackage

// File: rtl/step_sequencer_if.sv
// Control / pattern-write / audio-side signal bundle of the step sequencer.
//   master : user-input side (drives run and pattern writes, observes outputs)
//   slave  : the sequencer itself
// Signals:
//   run        level, 1 = play
//   wr_en      pattern write strobe
//   wr_addr    step index to write
//   wr_note    note code to store
//   wr_active  1 = step sounds, 0 = rest
//   note       current note code to the decoder
//   gate       1 = PWM output should sound
//   step_idx   current step index
//   step_pulse one-cycle strobe on each step entry
interface step_sequencer_if #(
  parameter int NUM_STEPS = 8
);
  localparam int AW = $clog2(NUM_STEPS);

  logic          run;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_note;
  logic          wr_active;
  logic [2:0]    note;
  logic          gate;
  logic [AW-1:0] step_idx;
  logic          step_pulse;

  modport master (
    output run, wr_en, wr_addr, wr_note, wr_active,
    input  note, gate, step_idx, step_pulse
  );

  modport slave (
    input  run, wr_en, wr_addr, wr_note, wr_active,
    output note, gate, step_idx, step_pulse
  );

endinterface

// File: rtl/step_timer.sv
// Per-step tick counter.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   clear        restart the step at tick 0 (wins over enable)
//   enable       advance the tick count this cycle
//   gate_window  gate may stay high after this edge
//   step_done    last tick of the step; next step entry happens this edge
module step_timer #(
  parameter int STEP_TICKS = 6000000,
  parameter int GATE_TICKS = 4500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic gate_window,
  output logic step_done
);

  localparam int TW = $clog2(STEP_TICKS);
  localparam logic [TW-1:0] LAST_TICK = TW'(STEP_TICKS - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TICKS - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (enable) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Gate is high for ticks 0..GATE_TICKS-1, so it must fall at the edge that
  // ends tick GATE_TICKS-1.
  assign gate_window = (tick_cnt_q < GATE_LAST);
  assign step_done   = enable && (tick_cnt_q == LAST_TICK);

endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer: plays NUM_STEPS programmable notes at a fixed tempo
// and produces the note code plus a gate for the PWM audio path.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (clears the pattern too)
//   bus   step_sequencer_if.slave: run, pattern write port, note/gate/step outputs
//
// state | meaning
// IDLE  | stopped; gate low, note and step_idx hold
// PLAY  | stepping through the pattern, one step every STEP_TICKS cycles
module step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STEPS  = 8,
  parameter int STEP_TICKS = 6000000,
  parameter int GATE_TICKS = 4500000
) (
  input  logic             clk,
  input  logic             rst,
  step_sequencer_if.slave  bus
);

  localparam int AW = $clog2(NUM_STEPS);

  state_t        state_q, state_d;
  step_t         pattern_q [NUM_STEPS];
  note_t         note_q, note_d;
  logic          gate_q, gate_d;
  logic [AW-1:0] step_idx_q, step_idx_d;
  logic          step_pulse_q, step_pulse_d;

  logic          timer_clear;
  logic          timer_en;
  logic          gate_window;
  logic          step_done;
  logic          enter;
  logic [AW-1:0] target;
  step_t         target_step;

  step_timer #(
    .STEP_TICKS (STEP_TICKS),
    .GATE_TICKS (GATE_TICKS)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (timer_clear),
    .enable      (timer_en),
    .gate_window (gate_window),
    .step_done   (step_done)
  );

  // Pattern registers: writes are accepted in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        pattern_q[i] <= STEP_CLEARED;
      end
    end else if (bus.wr_en) begin
      pattern_q[bus.wr_addr] <= '{active: bus.wr_active, note: note_t'(bus.wr_note)};
    end
  end

  always_comb begin
    state_d      = state_q;
    note_d       = note_q;
    gate_d       = 1'b0;
    step_idx_d   = step_idx_q;
    step_pulse_d = 1'b0;
    timer_clear  = 1'b1;
    timer_en     = 1'b0;
    enter        = 1'b0;
    target       = '0;
    target_step  = STEP_CLEARED;

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = PLAY;
          enter   = 1'b1;
          target  = '0;
        end
      end
      PLAY: begin
        // Stopping wins over a step entry falling on the same edge.
        if (!bus.run) begin
          state_d    = IDLE;
          step_idx_d = '0;
        end else begin
          timer_clear = 1'b0;
          timer_en    = 1'b1;
          if (step_done) begin
            enter  = 1'b1;
            target = step_idx_q + AW'(1);
          end else begin
            gate_d = gate_q & gate_window;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pattern is read from the registered copy, so a write landing on the
    // entry edge is only seen on the next visit to that step.
    if (enter) begin
      target_step  = pattern_q[target];
      step_idx_d   = target;
      note_d       = target_step.note;
      gate_d       = target_step.active;
      step_pulse_d = 1'b1;
      timer_clear  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      note_q       <= C4;
      gate_q       <= 1'b0;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_q       <= note_d;
      gate_q       <= gate_d;
      step_idx_q   <= step_idx_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign bus.note       = note_q;
  assign bus.gate       = gate_q;
  assign bus.step_idx   = step_idx_q;
  assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed testbench for step_sequencer (NUM_STEPS=8, STEP_TICKS=10, GATE_TICKS=4).
module tb_step_sequencer;

  localparam int NUM_STEPS  = 8;
  localparam int STEP_TICKS = 10;
  localparam int GATE_TICKS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b010, 3'b111};

  step_sequencer_if #(.NUM_STEPS(NUM_STEPS)) bus ();

  step_sequencer #(
    .NUM_STEPS  (NUM_STEPS),
    .STEP_TICKS (STEP_TICKS),
    .GATE_TICKS (GATE_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_note   = '0;
    bus.wr_active = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_step(input int addr, input logic [2:0] nt, input logic act);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'(addr);
    bus.wr_note   = nt;
    bus.wr_active = act;
    tick();
    bus.wr_en     = 1'b0;
  endtask

  task automatic write_pattern();
    for (int i = 0; i < 8; i++) write_step(i, seq[i], 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if ({bus.gate, bus.step_pulse, bus.note, bus.step_idx} !== 8'h00) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got gate=%b pulse=%b note=%b idx=%0d want all 0",
                 c, bus.gate, bus.step_pulse, bus.note, bus.step_idx);
      end
      tick();
    end
  endtask

  // Two full passes; the step-3 write during pass 0 must only show on pass 1.
  task automatic test_play(input bit write_mid);
    logic [2:0] exp_note;
    do_reset();
    write_pattern();
    bus.run = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 8; s++) begin
        for (int c = 0; c < STEP_TICKS; c++) begin
          exp_note = (write_mid && p == 1 && s == 3) ? 3'b111 : seq[s];
          n_cmp++;
          if (bus.step_pulse !== (c == 0)) begin
            n_err++;
            $display("FAIL play_pulse p=%0d s=%0d c=%0d got %b want %b", p, s, c, bus.step_pulse, (c == 0));
          end
          n_cmp++;
          if (bus.gate !== (c < GATE_TICKS)) begin
            n_err++;
            $display("FAIL play_gate p=%0d s=%0d c=%0d got %b want %b", p, s, c, bus.gate, (c < GATE_TICKS));
          end
          n_cmp++;
          if (bus.note !== exp_note) begin
            n_err++;
            $display("FAIL play_note p=%0d s=%0d c=%0d got %b want %b", p, s, c, bus.note, exp_note);
          end
          n_cmp++;
          if (bus.step_idx !== 3'(s)) begin
            n_err++;
            $display("FAIL play_idx p=%0d s=%0d c=%0d got %0d want %0d", p, s, c, bus.step_idx, s);
          end
          if (write_mid && p == 0 && s == 3 && c == 2) begin
            write_step(3, 3'b111, 1'b1);
          end else begin
            tick();
          end
        end
      end
    end
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_rest_step();
    do_reset();
    write_pattern();
    write_step(2, 3'b011, 1'b0);
    bus.run = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < STEP_TICKS; c++) begin
        n_cmp++;
        if (bus.gate !== (s != 2 && c < GATE_TICKS)) begin
          n_err++;
          $display("FAIL rest_gate s=%0d c=%0d got %b want %b", s, c, bus.gate, (s != 2 && c < GATE_TICKS));
        end
        n_cmp++;
        if (bus.step_pulse !== (c == 0)) begin
          n_err++;
          $display("FAIL rest_pulse s=%0d c=%0d got %b want %b", s, c, bus.step_pulse, (c == 0));
        end
        if (s == 2) begin
          n_cmp++;
          if (bus.note !== 3'b011) begin
            n_err++;
            $display("FAIL rest_note c=%0d got %b want 011", c, bus.note);
          end
        end
        tick();
      end
    end
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_stop_restart();
    do_reset();
    write_pattern();
    bus.run = 1'b1;
    tick();
    for (int g = 0; g < 53; g++) tick();   // now step 5, tick 3
    bus.run = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({bus.gate, bus.step_pulse, bus.step_idx, bus.note} !== {1'b0, 1'b0, 3'd0, 3'b101}) begin
        n_err++;
        $display("FAIL stop_hold c=%0d got gate=%b pulse=%b idx=%0d note=%b want 0 0 0 101",
                 c, bus.gate, bus.step_pulse, bus.step_idx, bus.note);
      end
      tick();
    end
    bus.run = 1'b1;
    tick();
    n_cmp++;
    if ({bus.gate, bus.step_pulse, bus.step_idx, bus.note} !== {1'b1, 1'b1, 3'd0, 3'b000}) begin
      n_err++;
      $display("FAIL restart got gate=%b pulse=%b idx=%0d note=%b want 1 1 0 000",
               bus.gate, bus.step_pulse, bus.step_idx, bus.note);
    end
    for (int c = 0; c < 9; c++) tick();    // last tick of step 0
    bus.run = 1'b0;
    tick();
    n_cmp++;
    if ({bus.gate, bus.step_pulse, bus.step_idx, bus.note} !== {1'b0, 1'b0, 3'd0, 3'b000}) begin
      n_err++;
      $display("FAIL stop_on_boundary got gate=%b pulse=%b idx=%0d note=%b want 0 0 0 000",
               bus.gate, bus.step_pulse, bus.step_idx, bus.note);
    end
    tick();
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    write_pattern();
    bus.run = 1'b1;
    tick();
    for (int g = 0; g < 12; g++) tick();   // step 1, tick 2
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.gate, bus.step_pulse, bus.step_idx, bus.note} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid got gate=%b pulse=%b idx=%0d note=%b want all 0",
               bus.gate, bus.step_pulse, bus.step_idx, bus.note);
    end
    rst = 1'b0;
    tick();
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < STEP_TICKS; c++) begin
        n_cmp++;
        if ({bus.gate, bus.step_pulse, bus.step_idx, bus.note} !== {1'b0, (c == 0), 3'(s), 3'b000}) begin
          n_err++;
          $display("FAIL cleared_replay s=%0d c=%0d got gate=%b pulse=%b idx=%0d note=%b want 0 %b %0d 000",
                   s, c, bus.gate, bus.step_pulse, bus.step_idx, bus.note, (c == 0), s);
        end
        tick();
      end
    end
    bus.run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_play(1'b0);
    test_rest_step();
    test_play(1'b1);
    test_stop_restart();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Cycles through a programmable pattern of NUM_STEPS notes at a fixed tempo.
- Drives the 3-bit note code into the note-to-interval decoder, plus a gate that enables the audible square wave.
- Owns the pattern storage, tempo timing and play/stop control; sits between the user-input logic and the PWM audio path.

Parameters:
- NUM_STEPS, 8, number of pattern steps; power of two, 2..16.
- STEP_TICKS, 6000000, clk cycles per step (0.5 s at 12 MHz); >= 2.
- GATE_TICKS, 4500000, clk cycles the gate stays high within an active step; 1 <= GATE_TICKS < STEP_TICKS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = play, 0 = stop.
- wr_en  input  1  pattern write strobe, sampled each cycle.
- wr_addr  input  $clog2(NUM_STEPS)  step index to write.
- wr_note  input  3  note code to store.
- wr_active  input  1  1 = step sounds, 0 = rest.
- note  output  3  current note code to the decoder.
- gate  output  1  1 = PWM output should sound.
- step_idx  output  $clog2(NUM_STEPS)  current step index.
- step_pulse  output  1  one-cycle strobe on each step entry.

Behaviour:
- All outputs registered. One clock (clk); reset synchronous, active-high (rst), fixed.
- Reset values:
  - State IDLE; tick_cnt 0.
  - note 3'b000 (C4); gate 0; step_idx 0; step_pulse 0.
  - All pattern entries note=000, active=0.
- Pattern storage:
  - NUM_STEPS entries of {active, note[2:0]}, one register per entry.
  - A write lands at the edge where wr_en=1. It becomes readable from the next cycle, and is accepted in every state.
- States: IDLE, PLAY.
  - IDLE: gate=0, step_pulse=0; note and step_idx hold their last values. At an edge with run=1 -> PLAY with step entry at index 0.
  - PLAY: run=0 sampled at an edge -> IDLE. At that same edge gate=0 and step_idx=0; note holds. No step_pulse is issued.
- Step entry (edge E):
  - step_idx <= target index; note <= pattern[target].note; gate <= pattern[target].active; step_pulse <= 1; tick_cnt <= 0.
  - Pattern is read as it stood before edge E, so a write to the target index at edge E is not seen.
- Within a step:
  - tick_cnt increments every cycle.
  - gate drops at the edge where tick_cnt reaches GATE_TICKS, so gate is high for exactly GATE_TICKS cycles counting the step_pulse cycle.
  - At the edge where tick_cnt == STEP_TICKS-1, the next step entry occurs, with index (step_idx+1) mod NUM_STEPS. The wrap NUM_STEPS-1 -> 0 is seamless.
  - Step period is exactly STEP_TICKS cycles.
- Latency: run sampled high at edge T -> step_pulse/gate/note valid after edge T (1 cycle).
- Simultaneous events:
  - rst has priority over everything.
  - run=0 has priority over a step entry in the same cycle.
  - A write to the currently playing step does not change note or gate until that step is next entered.
- Width rules:
  - tick_cnt is $clog2(STEP_TICKS) bits.
  - step_idx increment wraps naturally because NUM_STEPS is a power of two.
- Reset mid-play: returns to IDLE with gate=0 in the following cycle. The pattern is cleared.

Decomposition:
- Package seq_pkg:
  - note_t note codes: C4=000, D4=001, B4=010, E4=011, F4=100, A4=101, G4=110, C5=111.
  - state_t {IDLE, PLAY}.
  - step_t struct {active, note}.
- Sub-module step_timer: tick counter.
  - Inputs: clk, rst, clear, enable.
  - Outputs: gate_window, step_done.
  - Parameterised by STEP_TICKS and GATE_TICKS.

Test Plan (STEP_TICKS=10, GATE_TICKS=4, NUM_STEPS=8):
- Reset then idle 20 cycles -> gate=0, step_pulse=0, note=000, step_idx=0 throughout.
- Write steps 0..7 with notes 000,001,011,100,110,101,010,111, all active; raise run -> step_pulse every 10 cycles; note follows the written sequence; gate high 4 cycles, low 6 cycles per step; idx 7 -> 0 wrap repeats at cycle 80.
- Step 2 written active=0 -> gate stays 0 for all of step 2; step_pulse still fires; note=011.
- Write step 3 to 111 during step 3 -> current note unchanged; the next pass through step 3 outputs 111.
- Drop run mid-step 5 -> gate=0 and step_idx=0 the next cycle, no step_pulse; raise run again -> restarts at step 0 one cycle later.
- Assert rst during PLAY at tick_cnt=2 -> all outputs at reset values the next cycle; pattern cleared (replay gives gate=0 on every step).
